pd_seq_ctrl: RTL and testbench

//  Power-domain sequencer for the switchable ALU instance domain (the domain whose outputs
//  out1/out2 reach TOP). Drives clock enable, isolation, retention and power-switch controls
//  in a fixed order on power-down/power-up requests. Sits upstream of the switchable

---
 rtl/pd_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pd_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pd_seq_ctrl.sv
// Power-domain sequencer for the switchable ALU domain: clock gate, isolation, retention, power switch.
// Optional retention steps are enabled by defining PD_SEQ_RETENTION_EN.
//
// state     | meaning
// ON        | domain powered, clocked, outputs unclamped
// PD_CLK    | clock gated, waiting STEP_DLY
// PD_ISO    | outputs clamped, waiting STEP_DLY
// PD_SAVE   | retention save strobe held STEP_DLY (retention build only)
// PD_SW     | rail switched off, waiting for sw_ack=0
// OFF       | domain unpowered, isolated
// PU_SW     | rail switched on, waiting for sw_ack=1
// PU_RST    | retention restore strobe held STEP_DLY (retention build only)
// PU_ISO    | isolation released, waiting STEP_DLY
// PU_CLK    | clock enabled, waiting STEP_DLY before ON
module pd_seq_ctrl #(
   parameter int unsigned STEP_DLY = 2,
   parameter int unsigned ACK_TO   = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic pd_req,
   input  logic pu_req,
   input  logic sw_ack,
   output logic clk_en,
   output logic iso_en,
   output logic ret_save,
   output logic ret_restore,
   output logic sw_en,
   output logic busy,
   output logic dom_on,
   output logic err
);

   localparam int unsigned SW = $clog2(STEP_DLY + 1);
   localparam int unsigned TW = $clog2(ACK_TO + 1);
   localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_DLY - 1);
   localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TO);

   typedef enum logic [3:0] {
      S_ON, S_PD_CLK, S_PD_ISO, S_PD_SAVE, S_PD_SW,
      S_OFF, S_PU_SW, S_PU_RST, S_PU_ISO, S_PU_CLK
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [TW-1:0] to_q, to_d;
   logic          err_q, err_d;
   logic [6:0]    out_q, out_d;
   logic          step_done;
   logic          ack_wait;

   assign step_done = (step_q == '0);
   assign ack_wait  = ((state_q == S_PD_SW) && sw_ack) || ((state_q == S_PU_SW) && !sw_ack);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      to_d    = to_q;
      err_d   = err_q;

      case (state_q)
         S_ON: if (pd_req) begin
            state_d = S_PD_CLK;
            step_d  = STEP_LOAD;
         end
         S_PD_CLK: if (step_done) begin
            state_d = S_PD_ISO;
            step_d  = STEP_LOAD;
         end else begin
            step_d = step_q - SW'(1);
         end
         S_PD_ISO: if (step_done) begin
`ifdef PD_SEQ_RETENTION_EN
            state_d = S_PD_SAVE;
            step_d  = STEP_LOAD;
`else
            state_d = S_PD_SW;
            to_d    = '0;
`endif
         end else begin
            step_d = step_q - SW'(1);
         end
`ifdef PD_SEQ_RETENTION_EN
         S_PD_SAVE: if (step_done) begin
            state_d = S_PD_SW;
            to_d    = '0;
         end else begin
            step_d = step_q - SW'(1);
         end
`endif
         S_PD_SW: if (!sw_ack) state_d = S_OFF;
         S_OFF: if (pu_req) begin
            state_d = S_PU_SW;
            to_d    = '0;
         end
         S_PU_SW: if (sw_ack) begin
`ifdef PD_SEQ_RETENTION_EN
            state_d = S_PU_RST;
`else
            state_d = S_PU_ISO;
`endif
            step_d = STEP_LOAD;
         end
`ifdef PD_SEQ_RETENTION_EN
         S_PU_RST: if (step_done) begin
            state_d = S_PU_ISO;
            step_d  = STEP_LOAD;
         end else begin
            step_d = step_q - SW'(1);
         end
`endif
         S_PU_ISO: if (step_done) begin
            state_d = S_PU_CLK;
            step_d  = STEP_LOAD;
         end else begin
            step_d = step_q - SW'(1);
         end
         S_PU_CLK: if (step_done) begin
            state_d = S_ON;
         end else begin
            step_d = step_q - SW'(1);
         end
         default: state_d = S_ON;
      endcase

      // The FSM keeps waiting after a timeout; the counter just saturates.
      if (ack_wait) begin
         if (to_q != ACK_LIM) to_d = to_q + TW'(1);
         if (to_d == ACK_LIM) err_d = 1'b1;
      end

      // {clk_en, iso_en, ret_save, ret_restore, sw_en, busy, dom_on}
      case (state_d)
         S_ON:      out_d = 7'b1000101;
         S_PD_CLK:  out_d = 7'b0000110;
         S_PD_ISO:  out_d = 7'b0100110;
`ifdef PD_SEQ_RETENTION_EN
         S_PD_SAVE: out_d = 7'b0110110;
         S_PU_RST:  out_d = 7'b0101110;
`endif
         S_PD_SW:   out_d = 7'b0100010;
         S_OFF:     out_d = 7'b0100000;
         S_PU_SW:   out_d = 7'b0100110;
         S_PU_ISO:  out_d = 7'b0000110;
         S_PU_CLK:  out_d = 7'b1000110;
         default:   out_d = 7'b1000101;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ON;
         step_q  <= '0;
         to_q    <= '0;
         err_q   <= 1'b0;
         out_q   <= 7'b1000101;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         to_q    <= to_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   assign clk_en      = out_q[6];
   assign iso_en      = out_q[5];
   assign ret_save    = out_q[4];
   assign ret_restore = out_q[3];
   assign sw_en       = out_q[2];
   assign busy        = out_q[1];
   assign dom_on      = out_q[0];
   assign err         = err_q;

endmodule

// File: tb/tb_pd_seq_ctrl.sv
// Bench for pd_seq_ctrl: per-cycle vector table with a scoreboard queue, plus latency sequences
// driven by a lagging switch-ack model. Honours PD_SEQ_RETENTION_EN like the design.
module tb_pd_seq_ctrl;

   localparam int STEP  = 2;
   localparam int ACKTO = 8;
`ifdef PD_SEQ_RETENTION_EN
   localparam bit RET = 1'b1;
`else
   localparam bit RET = 1'b0;
`endif

   // {clk_en, iso_en, ret_save, ret_restore, sw_en, busy, dom_on, err}
   localparam logic [7:0] ON_V     = 8'b10001010;
   localparam logic [7:0] PDCLK_V  = 8'b00001100;
   localparam logic [7:0] PDISO_V  = 8'b01001100;
   localparam logic [7:0] PDSAVE_V = 8'b01101100;
   localparam logic [7:0] PDSW_V   = 8'b01000100;
   localparam logic [7:0] OFF_V    = 8'b01000000;
   localparam logic [7:0] PUSW_V   = 8'b01001100;
   localparam logic [7:0] PURST_V  = 8'b01011100;
   localparam logic [7:0] PUISO_V  = 8'b00001100;
   localparam logic [7:0] PUCLK_V  = 8'b10001100;
   localparam logic [7:0] ERR_B    = 8'b00000001;

   logic clk = 1'b0;
   logic rst = 1'b1, pd_req = 1'b0, pu_req = 1'b0, sw_ack_drv = 1'b1;
   logic use_model = 1'b0;
   logic ack_d1 = 1'b1, ack_d2 = 1'b1;
   logic sw_ack;
   logic clk_en, iso_en, ret_save, ret_restore, sw_en, busy, dom_on, err;
   logic ret_seen = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic       rst, pd, pu, ack;
      logic [7:0] exp;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   pd_seq_ctrl #(.STEP_DLY(STEP), .ACK_TO(ACKTO)) dut (
      .clk(clk), .rst(rst), .pd_req(pd_req), .pu_req(pu_req), .sw_ack(sw_ack),
      .clk_en(clk_en), .iso_en(iso_en), .ret_save(ret_save), .ret_restore(ret_restore),
      .sw_en(sw_en), .busy(busy), .dom_on(dom_on), .err(err)
   );

   // Rail model: ack follows sw_en with a lag, so the DUT sees the change on the third edge.
   always @(posedge clk) begin
      ack_d1 <= sw_en;
      ack_d2 <= ack_d1;
      if (ret_save || ret_restore) ret_seen <= 1'b1;
   end
   assign sw_ack = use_model ? ack_d2 : sw_ack_drv;

   wire [7:0] obs = {clk_en, iso_en, ret_save, ret_restore, sw_en, busy, dom_on, err};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input string tag, input int n, input logic r, input logic p,
                      input logic u, input logic a, input logic [7:0] e);
      vec_t v;
      v.tag = tag; v.rst = r; v.pd = p; v.pu = u; v.ack = a; v.exp = e;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic measure(input string name, input bit to_on, input int exp_lat,
                          input logic [7:0] exp_out);
      int  cnt;
      bit  done;
      cnt  = 0;
      done = 1'b0;
      while (!done && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
         pd_req = 1'b0;
         pu_req = 1'b0;
         if (!busy && (dom_on == to_on)) done = 1'b1;
      end
      check({name, "_reached"}, 32'(done), 32'd1);
      check({name, "_latency"}, 32'(cnt), 32'(exp_lat));
      check({name, "_outputs"}, 32'(obs), 32'(exp_out));
   endtask

   initial begin
      logic [7:0] expv;

      // reset and idle
      add("rst", 3, 1, 0, 0, 1, ON_V);
      add("idle", 2, 0, 0, 0, 1, ON_V);
      // power-down, ack drops on the third edge after sw_en falls
      add("pd_clk", 1, 0, 1, 0, 1, PDCLK_V);
      add("pd_clk", 1, 0, 0, 0, 1, PDCLK_V);
      add("pd_iso", 2, 0, 0, 0, 1, PDISO_V);
`ifdef PD_SEQ_RETENTION_EN
      add("pd_save", 2, 0, 0, 0, 1, PDSAVE_V);
`endif
      add("pd_sw", 3, 0, 0, 0, 1, PDSW_V);
      add("pd_off", 3, 0, 0, 0, 0, OFF_V);
      // power-up, ack rises on the third edge after sw_en rises
      add("pu_sw", 1, 0, 0, 1, 0, PUSW_V);
      add("pu_sw", 2, 0, 0, 0, 0, PUSW_V);
`ifdef PD_SEQ_RETENTION_EN
      add("pu_rst", 2, 0, 0, 0, 1, PURST_V);
`endif
      add("pu_iso", 2, 0, 0, 0, 1, PUISO_V);
      add("pu_clk", 2, 0, 0, 0, 1, PUCLK_V);
      add("pu_on", 2, 0, 0, 0, 1, ON_V);
      // both requests held: down first, up starts the edge after OFF
      add("both_clk", 2, 0, 1, 1, 1, PDCLK_V);
      add("both_iso", 2, 0, 1, 1, 1, PDISO_V);
`ifdef PD_SEQ_RETENTION_EN
      add("both_save", 2, 0, 1, 1, 1, PDSAVE_V);
`endif
      add("both_sw", 1, 0, 1, 1, 1, PDSW_V);
      add("both_off", 1, 0, 1, 1, 0, OFF_V);
      add("both_pusw", 1, 0, 1, 1, 0, PUSW_V);
`ifdef PD_SEQ_RETENTION_EN
      add("both_rst", 2, 0, 0, 0, 1, PURST_V);
`endif
      add("both_puiso", 2, 0, 0, 0, 1, PUISO_V);
      add("both_puclk", 2, 0, 0, 0, 1, PUCLK_V);
      add("both_on", 2, 0, 0, 0, 1, ON_V);
      // ack timeout in PD_SW
      add("to_clk", 1, 0, 1, 0, 1, PDCLK_V);
      add("to_clk", 1, 0, 0, 0, 1, PDCLK_V);
      add("to_iso", 2, 0, 0, 0, 1, PDISO_V);
`ifdef PD_SEQ_RETENTION_EN
      add("to_save", 2, 0, 0, 0, 1, PDSAVE_V);
`endif
      add("to_wait", 8, 0, 0, 0, 1, PDSW_V);
      add("to_err", 4, 0, 0, 0, 1, PDSW_V | ERR_B);
      add("to_off", 2, 0, 0, 0, 0, OFF_V | ERR_B);
      add("to_rst", 1, 1, 0, 0, 0, ON_V);
      add("to_idle", 1, 0, 0, 0, 1, ON_V);
      // reset in the middle of power-down
      add("mid_clk", 1, 0, 1, 0, 1, PDCLK_V);
      add("mid_clk", 1, 0, 0, 0, 1, PDCLK_V);
`ifdef PD_SEQ_RETENTION_EN
      add("mid_iso", 2, 0, 0, 0, 1, PDISO_V);
      add("mid_save", 1, 0, 0, 0, 1, PDSAVE_V);
`else
      add("mid_iso", 1, 0, 0, 0, 1, PDISO_V);
`endif
      add("mid_rst", 1, 1, 0, 0, 1, ON_V);
      add("mid_on", 3, 0, 0, 0, 1, ON_V);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst        = tbl[i].rst;
         pd_req     = tbl[i].pd;
         pu_req     = tbl[i].pu;
         sw_ack_drv = tbl[i].ack;
         sb_q.push_back(tbl[i].exp);
         @(posedge clk);
         #1;
         expv = sb_q.pop_front();
         check($sformatf("%s[%0d]", tbl[i].tag, i), 32'(obs), 32'(expv));
      end

      // full sequences against the lagging rail model
      @(negedge clk);
      use_model = 1'b1;
      repeat (3) @(negedge clk);
      pd_req = 1'b1;
      measure("lat_down", 1'b0, 4 + (RET ? 3 : 2) * STEP, OFF_V);
      repeat (2) @(negedge clk);
      pu_req = 1'b1;
      measure("lat_up", 1'b1, 4 + (RET ? 3 : 2) * STEP, ON_V);

      check("ret_strobes_seen", 32'(ret_seen), 32'(RET));
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
